// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry in-order buffer of {instruction, pc+4} with valid/ready on both sides and a sync flush.
// Optional perf counters (stall_cycles, flush_count) are compiled in when IFID_PERF_EN is defined.
module if_id_queue #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] if_instruction,
  input  logic [WIDTH-1:0] if_pc_plus4,
  input  logic             if_valid,
  output logic             if_ready,
  output logic [WIDTH-1:0] id_instruction,
  output logic [WIDTH-1:0] id_pc_plus4,
  output logic             id_valid,
  input  logic             id_ready,
  input  logic             flush,
`ifdef IFID_PERF_EN
  output logic [31:0]      stall_cycles,
  output logic [15:0]      flush_count,
`endif
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [WIDTH-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No push-through when full: if_ready ignores a simultaneous pop.
  assign if_ready       = (count < CNT_W'(DEPTH));
  assign id_valid       = (count != '0);
  assign push           = if_valid & if_ready;
  assign pop            = id_valid & id_ready;
  assign id_instruction = id_valid ? mem_instr[rd_ptr] : '0;
  assign id_pc_plus4    = id_valid ? mem_pc[rd_ptr]    : '0;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage is never cleared; flush and reset only move the pointers.
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) begin
      mem_instr[wr_ptr] <= if_instruction;
      mem_pc[wr_ptr]    <= if_pc_plus4;
    end
  end

`ifdef IFID_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (if_valid && !if_ready && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (flush && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] if_instruction;
  logic [WIDTH-1:0] if_pc_plus4;
  logic             if_valid;
  logic             if_ready;
  logic [WIDTH-1:0] id_instruction;
  logic [WIDTH-1:0] id_pc_plus4;
  logic             id_valid;
  logic             id_ready;
  logic             flush;
  logic [CW-1:0]    count;
`ifdef IFID_PERF_EN
  logic [31:0]      stall_cycles;
  logic [15:0]      flush_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;
  entry_t mq[$];
  int     m_stalls;
  int     m_flushes;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .if_instruction (if_instruction),
    .if_pc_plus4    (if_pc_plus4),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .id_instruction (id_instruction),
    .id_pc_plus4    (id_pc_plus4),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .flush          (flush),
`ifdef IFID_PERF_EN
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count),
`endif
    .count          (count)
  );

  always #5 clock = ~clock;

  // Model-side expectations
  function automatic logic [WIDTH-1:0] exp_instr();
    return (mq.size() != 0) ? mq[0].instr : '0;
  endfunction
  function automatic logic [WIDTH-1:0] exp_pc();
    return (mq.size() != 0) ? mq[0].pc : '0;
  endfunction

  // Drives one cycle starting from a negedge and advances the model at the posedge.
  task automatic tick(input logic v, input logic [WIDTH-1:0] ins, input logic [WIDTH-1:0] pc,
                      input logic rdy, input logic fl);
    bit can_push, do_push, do_pop;
    if_valid = v; if_instruction = ins; if_pc_plus4 = pc; id_ready = rdy; flush = fl;
    @(posedge clock);
    can_push = (mq.size() < DEPTH);
    do_push  = v && can_push;
    do_pop   = rdy && (mq.size() != 0);
    if (reset) begin
      mq.delete(); m_stalls = 0; m_flushes = 0;
    end else if (fl) begin
      mq.delete(); m_flushes++;
    end else begin
      if (v && !can_push) m_stalls++;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{instr: ins, pc: pc});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (id_valid !== 1'b0 || id_instruction !== '0 || id_pc_plus4 !== '0 || if_ready !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL reset: valid=%0b instr=%h pc=%h ready=%0b count=%0d, want 0/0/0/1/0",
               id_valid, id_instruction, id_pc_plus4, if_ready, count);
    end
  endtask

  task automatic test_single_push();
    tick(1'b1, 32'h2008_0005, 32'h4, 1'b0, 1'b0);
    checks++;
    if (id_valid !== 1'b1 || id_instruction !== 32'h2008_0005 || id_pc_plus4 !== 32'h4 || count !== CW'(1)) begin
      errors++;
      $display("FAIL single_push: valid=%0b instr=%h pc=%h count=%0d, want 1/20080005/4/1",
               id_valid, id_instruction, id_pc_plus4, count);
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (id_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL single_pop: valid=%0b count=%0d, want 0/0", id_valid, count);
    end
  endtask

  task automatic test_full();
    apply_reset();
    tick(1'b1, 32'hAAAA_0001, 32'h100, 1'b0, 1'b0);
    tick(1'b1, 32'hBBBB_0002, 32'h104, 1'b0, 1'b0);
    checks++;
    if (count !== CW'(2) || if_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state: count=%0d ready=%0b, want 2/0", count, if_ready);
    end
    tick(1'b1, 32'hCCCC_0003, 32'h108, 1'b0, 1'b0);
    checks++;
    if (count !== CW'(2) || id_instruction !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL full_reject: count=%0d head=%h, want 2/aaaa0001", count, id_instruction);
    end
    // Pop while C is still offered: no push-through, so C stays out.
    tick(1'b1, 32'hCCCC_0003, 32'h108, 1'b1, 1'b0);
    checks++;
    if (id_instruction !== 32'hBBBB_0002 || id_pc_plus4 !== 32'h104 || count !== CW'(1) || if_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: head=%h pc=%h count=%0d ready=%0b, want bbbb0002/104/1/1",
               id_instruction, id_pc_plus4, count, if_ready);
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] words [5];
    words[0] = 32'hA000_000A; words[1] = 32'hB000_000B; words[2] = 32'hC000_000C;
    words[3] = 32'hD000_000D; words[4] = 32'hE000_000E;
    apply_reset();
    tick(1'b1, words[0], 32'h200, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (id_instruction !== words[i-1] || count !== CW'(1)) begin
        errors++;
        $display("FAIL stream_%0d: head=%h count=%0d, want %h/1", i, id_instruction, count, words[i-1]);
      end
      tick(1'b1, words[i], 32'h200 + 32'(4 * i), 1'b1, 1'b0);
    end
    checks++;
    if (id_instruction !== words[4] || id_pc_plus4 !== 32'h210 || count !== CW'(1)) begin
      errors++;
      $display("FAIL stream_last: head=%h pc=%h count=%0d, want %h/210/1", id_instruction, id_pc_plus4, count, words[4]);
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    apply_reset();
    tick(1'b1, 32'h1111_1111, 32'h300, 1'b0, 1'b0);
    tick(1'b1, 32'h2222_2222, 32'h304, 1'b0, 1'b0);
    tick(1'b1, 32'hDEAD_BEEF, 32'h308, 1'b1, 1'b1);
    checks++;
    if (count !== '0 || id_valid !== 1'b0 || id_instruction !== '0) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%0b instr=%h, want 0/0/0", count, id_valid, id_instruction);
    end
`ifdef IFID_PERF_EN
    checks++;
    if (flush_count !== 16'd1) begin
      errors++;
      $display("FAIL flush_count: got %0d want 1", flush_count);
    end
`endif
    tick(1'b1, 32'h3333_3333, 32'h400, 1'b0, 1'b0);
    checks++;
    if (id_instruction !== 32'h3333_3333 || id_pc_plus4 !== 32'h400 || count !== CW'(1)) begin
      errors++;
      $display("FAIL post_flush: head=%h pc=%h count=%0d, want 33333333/400/1", id_instruction, id_pc_plus4, count);
    end
  endtask

  task automatic test_perf();
`ifdef IFID_PERF_EN
    apply_reset();
    tick(1'b1, 32'h5, 32'h4, 1'b0, 1'b0);
    tick(1'b1, 32'h6, 32'h8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h7, 32'hC, 1'b0, 1'b0);
    checks++;
    if (stall_cycles !== 32'd3) begin
      errors++;
      $display("FAIL stall_cycles: got %0d want 3", stall_cycles);
    end
    apply_reset();
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
      errors++;
      $display("FAIL perf_reset: stall=%0d flush=%0d want 0/0", stall_cycles, flush_count);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    tick(1'b1, 32'h9999_0001, 32'h500, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1'b1, 32'h9999_0002, 32'h504, 1'b0, 1'b0);
    checks++;
    if (count !== '0 || id_valid !== 1'b0 || if_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: count=%0d valid=%0b ready=%0b, want 0/0/1", count, id_valid, if_ready);
    end
  endtask

  task automatic test_random();
    logic v, r, f;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 65);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 5);
      tick(v, $urandom, $urandom, r, f);
      checks++;
      if (count !== CW'(mq.size()) || id_valid !== (mq.size() != 0) || if_ready !== (mq.size() < DEPTH) ||
          id_instruction !== exp_instr() || id_pc_plus4 !== exp_pc()) begin
        errors++;
        $display("FAIL random_%0d: count=%0d valid=%0b ready=%0b instr=%h pc=%h, want %0d/%0b/%0b/%h/%h",
                 i, count, id_valid, if_ready, id_instruction, id_pc_plus4,
                 mq.size(), mq.size() != 0, mq.size() < DEPTH, exp_instr(), exp_pc());
      end
`ifdef IFID_PERF_EN
      checks++;
      if (stall_cycles !== 32'(m_stalls) || flush_count !== 16'(m_flushes)) begin
        errors++;
        $display("FAIL random_perf_%0d: stall=%0d flush=%0d, want %0d/%0d", i, stall_cycles, flush_count, m_stalls, m_flushes);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instruction = '0; if_pc_plus4 = '0; id_ready = 1'b0; flush = 1'b0;
    m_stalls = 0; m_flushes = 0;
    @(negedge clock);
    test_reset();
    test_single_push();
    test_full();
    test_streaming();
    test_flush();
    test_perf();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
